// File: rtl/shifter_pkg.sv
// shifter_pkg: opcodes, shift-class decode and the stage control payload shared by the pipelined shifter.
package shifter_pkg;
  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_ROL = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b110;
  typedef enum logic [2:0] {LOGIC_L, LOGIC_R, ROT_L, ROT_R, ARITH_R} shift_class_e;
  typedef struct packed {
    shift_class_e cls;
    logic         sign;
  } stage_ctrl_t;
  // 100/101 alias SLL/SRL and 111 aliases SRA, so only op[2:1]==11 marks arithmetic
  function automatic shift_class_e decode(input logic [2:0] op);
    return op[2:1] == 2'b11 ? ARITH_R :
           op == OP_ROL     ? ROT_L   :
           op == OP_ROR     ? ROT_R   :
           op[0]            ? LOGIC_R : LOGIC_L;
  endfunction
endpackage

// File: rtl/shifter_stage.sv
// shifter_stage: one registered power-of-two shift/rotate step with valid/ready handshake.
// Ports: in_* (valid/ready/data/amt/tag/ctrl) from the previous stage, out_* to the next stage.
// SHIFTER_FLAGS_EN adds in_carry/out_carry, a carry bit carried alongside the data.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int STAGE_IDX = 0,
  localparam int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_amt,
  input  logic [TAG_W-1:0] in_tag,
  input  stage_ctrl_t      in_ctrl,
`ifdef SHIFTER_FLAGS_EN
  input  logic             in_carry,
  output logic             out_carry,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LOG2W-1:0] out_amt,
  output logic [TAG_W-1:0] out_tag,
  output stage_ctrl_t      out_ctrl
);
  localparam int SH = 1 << STAGE_IDX;
  logic [WIDTH-1:0] step;
  // SRA fills with the sign captured at stage 0, not the current top bit
  always_comb
    step = !in_amt[STAGE_IDX]        ? in_data :
           in_ctrl.cls == LOGIC_L    ? {in_data[WIDTH-SH-1:0], {SH{1'b0}}} :
           in_ctrl.cls == ROT_L      ? {in_data[WIDTH-SH-1:0], in_data[WIDTH-1:WIDTH-SH]} :
           in_ctrl.cls == ROT_R      ? {in_data[SH-1:0], in_data[WIDTH-1:SH]} :
           in_ctrl.cls == ARITH_R    ? {{SH{in_ctrl.sign}}, in_data[WIDTH-1:SH]} :
                                       {{SH{1'b0}}, in_data[WIDTH-1:SH]};
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_amt   <= '0;
      out_tag   <= '0;
      out_ctrl  <= '0;
`ifdef SHIFTER_FLAGS_EN
      out_carry <= 1'b0;
`endif
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data  <= step;
        out_amt   <= in_amt;
        out_tag   <= in_tag;
        out_ctrl  <= in_ctrl;
`ifdef SHIFTER_FLAGS_EN
        out_carry <= in_carry;
`endif
      end
    end
endmodule

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: LOG2W-stage SLL/SRL/SRA/ROL/ROR unit with valid/ready on both sides.
// Ports: clk, rst, in_valid/in_ready/in_data/in_op/in_amt/in_tag, out_valid/out_ready/out_data/out_tag.
// SHIFTER_FLAGS_EN adds out_zero and out_carry.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [LOG2W-1:0] in_amt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef SHIFTER_FLAGS_EN
  output logic             out_zero,
  output logic             out_carry,
`endif
  output logic [TAG_W-1:0] out_tag
);
  logic [LOG2W:0] v, r;
  logic [WIDTH-1:0] d [LOG2W+1];
  logic [LOG2W-1:0] a [LOG2W+1];
  logic [TAG_W-1:0] t [LOG2W+1];
  stage_ctrl_t c [LOG2W+1];
  logic unused_tail;
  assign v[0] = in_valid;
  assign d[0] = in_data;
  assign a[0] = in_amt;
  assign t[0] = in_tag;
  assign c[0] = '{cls: decode(in_op), sign: in_data[WIDTH-1]};
  assign r[LOG2W] = out_ready;
  assign in_ready = r[0] && !rst;
  assign out_valid = v[LOG2W];
  assign out_data = d[LOG2W];
  assign out_tag = t[LOG2W];
  assign unused_tail = ^{a[LOG2W], c[LOG2W]};
`ifdef SHIFTER_FLAGS_EN
  logic [LOG2W:0] y;
  logic [LOG2W-1:0] neg_amt;
  // left shifts/rotates lose bit WIDTH-amt last, right ones bit amt-1; modulo-WIDTH negate gives WIDTH-amt
  assign neg_amt = -in_amt;
  assign y[0] = in_amt == '0 ? 1'b0 :
                (c[0].cls == LOGIC_L || c[0].cls == ROT_L) ? in_data[neg_amt] : in_data[in_amt - LOG2W'(1)];
  assign out_carry = y[LOG2W];
  assign out_zero = out_valid && out_data == '0;
`endif
  for (genvar k = 0; k < LOG2W; k++) begin : g
    shifter_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W), .STAGE_IDX(k)) u_stage (
      .clk,
      .rst,
      .in_valid (v[k]),
      .in_ready (r[k]),
      .in_data  (d[k]),
      .in_amt   (a[k]),
      .in_tag   (t[k]),
      .in_ctrl  (c[k]),
`ifdef SHIFTER_FLAGS_EN
      .in_carry (y[k]),
      .out_carry(y[k+1]),
`endif
      .out_valid(v[k+1]),
      .out_ready(r[k+1]),
      .out_data (d[k+1]),
      .out_amt  (a[k+1]),
      .out_tag  (t[k+1]),
      .out_ctrl (c[k+1])
    );
  end
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: scoreboard bench for pipelined_shifter at WIDTH=32.
module tb_pipelined_shifter;
  localparam int W = 32;
  localparam int TW = 8;
  localparam int LW = 5;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, in_ready, out_valid;
  logic [W-1:0] in_data = '0, out_data;
  logic [2:0] in_op = '0;
  logic [LW-1:0] in_amt = '0;
  logic [TW-1:0] in_tag = '0, out_tag;
`ifdef SHIFTER_FLAGS_EN
  logic out_zero, out_carry;
`endif
  typedef struct {
    logic [W-1:0]  d;
    logic [TW-1:0] t;
    logic          z;
    logic          c;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, rdy_mode = 0;
  always #5 clk = ~clk;
  pipelined_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_op(in_op), .in_amt(in_amt), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
`ifdef SHIFTER_FLAGS_EN
    .out_zero(out_zero), .out_carry(out_carry),
`endif
    .out_data(out_data), .out_tag(out_tag)
  );
  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [2:0] op, input logic [LW-1:0] n);
    case (op)
      3'd0, 3'd4: return x << n;
      3'd1, 3'd5: return x >> n;
      3'd2: return (x << n) | (x >> (W - int'(n)));
      3'd3: return (x >> n) | (x << (W - int'(n)));
      default: return $signed(x) >>> n;
    endcase
  endfunction
  function automatic exp_t mk(input logic [W-1:0] x, input logic [2:0] op, input logic [LW-1:0] n,
                              input logic [TW-1:0] tag, input logic [W-1:0] res);
    exp_t e;
    e.d = res;
    e.t = tag;
    e.z = res == '0;
    e.c = n == 0 ? 1'b0 : op == 3'd2 ? res[0] : op == 3'd3 ? res[W-1] :
          (op == 3'd0 || op == 3'd4) ? x[W-int'(n)] : x[int'(n)-1];
    return e;
  endfunction
  // out_ready: 0 = always 1, 1 = random each cycle, 2 = driven by the main sequence
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end
  // monitor: pops the scoreboard on each delivery and checks held outputs while stalled
  initial begin
    exp_t e;
    logic held;
    logic [W-1:0] hd;
    logic [TW-1:0] ht;
    held = 0;
    forever begin
      @(negedge clk);
      if (!rst && held) begin
        total++;
        assert (out_valid === 1'b1 && out_data === hd && out_tag === ht) else begin
          bad++;
          $error("FAIL hold: valid=%b data=%h tag=%h, need valid=1 data=%h tag=%h", out_valid, out_data, out_tag, hd, ht);
        end
      end
      if (!rst && out_valid === 1'b1 && out_ready) begin
        total++;
        assert (q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected: data=%h tag=%h, need no output", out_data, out_tag);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          total++;
          assert (out_data === e.d) else begin
            bad++;
            $error("FAIL data tag=%0d: got %h, need %h", e.t, out_data, e.d);
          end
          total++;
          assert (out_tag === e.t) else begin
            bad++;
            $error("FAIL tag: got %0d, need %0d", out_tag, e.t);
          end
`ifdef SHIFTER_FLAGS_EN
          total++;
          assert (out_zero === e.z && out_carry === e.c) else begin
            bad++;
            $error("FAIL flags tag=%0d: got z=%b c=%b, need z=%b c=%b", e.t, out_zero, out_carry, e.z, e.c);
          end
`endif
        end
      end
      held = !rst && out_valid === 1'b1 && !out_ready;
      hd = out_data;
      ht = out_tag;
    end
  end
  task automatic send(input logic [W-1:0] x, input logic [2:0] op, input logic [LW-1:0] n,
                      input logic [TW-1:0] tag, input logic [W-1:0] res);
    exp_t e;
    int k;
    logic ok;
    e = mk(x, op, n, tag, res);
    in_valid = 1;
    in_data = x;
    in_op = op;
    in_amt = n;
    in_tag = tag;
    k = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      if (ok) q.push_back(e);
      @(posedge clk);
      #1;
      k++;
    end while (!ok && k < 300);
    in_valid = 0;
    total++;
    assert (ok) else begin
      bad++;
      $error("FAIL send_timeout tag=%0d: in_ready=%b, need 1", tag, in_ready);
    end
  endtask
  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    #1;
    total++;
    assert (q.size() == 0) else begin
      bad++;
      $error("FAIL drain: %0d results missing, need 0", q.size());
    end
  endtask
  task automatic latency(input string name);
    int n;
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    assert (n == 5) else begin
      bad++;
      $error("FAIL latency %s: got %0d, need 5", name, n);
    end
  endtask
  initial begin
    logic [2:0] ops [8];
    logic [W-1:0] res [8];
    logic [W-1:0] x;
    logic [2:0] op;
    logic [LW-1:0] n;
    ops = '{3'd0, 3'd1, 3'd6, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    res = '{32'h0000_0010, 32'h0800_0000, 32'hF800_0000, 32'h0000_0018, 32'h1800_0000,
            32'h0000_0010, 32'h0800_0000, 32'hF800_0000};
    rst = 1;
    in_valid = 1;
    in_data = 32'hFFFF_FFFF;
    in_amt = 5'd3;
    repeat (2) begin
      @(posedge clk);
      #1;
      total++;
      assert (in_ready === 1'b0 && out_valid === 1'b0 && out_data === '0 && out_tag === '0) else begin
        bad++;
        $error("FAIL reset: in_ready=%b valid=%b data=%h tag=%h, need 0 0 0 0", in_ready, out_valid, out_data, out_tag);
      end
    end
`ifdef SHIFTER_FLAGS_EN
    total++;
    assert (out_zero === 1'b0 && out_carry === 1'b0) else begin
      bad++;
      $error("FAIL reset_flags: z=%b c=%b, need 0 0", out_zero, out_carry);
    end
`endif
    rst = 0;
    in_valid = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      total++;
      assert (in_ready === 1'b1 && out_valid === 1'b0) else begin
        bad++;
        $error("FAIL post_reset: in_ready=%b valid=%b, need 1 0", in_ready, out_valid);
      end
    end
    for (int i = 0; i < 8; i++) begin
      send(32'h8000_0001, ops[i], 5'd4, TW'(i), res[i]);
      latency($sformatf("op%0d", ops[i]));
      drain();
    end
    for (int i = 0; i < 8; i++) send(32'hDEAD_BEEF, 3'(i), 5'd0, TW'(10 + i), 32'hDEAD_BEEF);
    send(32'hDEAD_BEEF, 3'd6, 5'd31, 8'd20, 32'hFFFF_FFFF);
    send(32'hDEAD_BEEF, 3'd2, 5'd31, 8'd21, 32'hEF56_DF77);
    drain();
    rdy_mode = 1;
    for (int i = 0; i < 20; i++) begin
      x = $urandom;
      op = 3'($urandom_range(0, 7));
      n = 5'($urandom_range(0, 31));
      send(x, op, n, TW'(i), model(x, op, n));
    end
    drain();
    rdy_mode = 2;
    @(posedge clk);
    #1;
    out_ready = 0;
    for (int i = 0; i < 5; i++) send(32'h0000_00F0, 3'd3, 5'(i), TW'(40 + i), model(32'h0000_00F0, 3'd3, 5'(i)));
    total++;
    assert (in_ready === 1'b0 && out_valid === 1'b1) else begin
      bad++;
      $error("FAIL full_stall: in_ready=%b valid=%b, need 0 1", in_ready, out_valid);
    end
    out_ready = 1;
    #1;
    total++;
    assert (in_ready === 1'b1) else begin
      bad++;
      $error("FAIL ready_ripple: in_ready=%b, need 1", in_ready);
    end
    rdy_mode = 0;
    drain();
    for (int i = 0; i < 3; i++) send(32'h1234_5678, 3'd0, 5'd1, TW'(50 + i), 32'h2468_ACF0);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    q.delete();
    repeat (8) begin
      @(posedge clk);
      #1;
      total++;
      assert (out_valid === 1'b0) else begin
        bad++;
        $error("FAIL flushed: valid=%b tag=%h, need valid=0", out_valid, out_tag);
      end
    end
    send(32'hDEAD_BEEF, 3'd3, 5'd8, 8'd60, 32'hEFDE_ADBE);
    drain();
`ifdef SHIFTER_FLAGS_EN
    send(32'h8000_0000, 3'd0, 5'd1, 8'd70, 32'h0);
    latency("flag_sll");
    total++;
    assert (out_data === 32'h0 && out_zero === 1'b1 && out_carry === 1'b1) else begin
      bad++;
      $error("FAIL flag_sll: data=%h z=%b c=%b, need 0 1 1", out_data, out_zero, out_carry);
    end
    drain();
    send(32'h0000_0002, 3'd1, 5'd1, 8'd71, 32'h1);
    latency("flag_srl");
    total++;
    assert (out_data === 32'h1 && out_zero === 1'b0 && out_carry === 1'b0) else begin
      bad++;
      $error("FAIL flag_srl: data=%h z=%b c=%b, need 1 0 0", out_data, out_zero, out_carry);
    end
    drain();
`endif
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
